// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready flow control and a
// two-entry skid buffer (main + skid). Supports flush and zero-bubble outputs.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard all held entries
//   in_valid / in_ready   upstream handshake (in_ready depends on state/reset only)
//   *_in                  payload fields from upstream
//   out_valid / out_ready downstream handshake
//   *_out                 payload fields from the main register
//   occupancy             number of held entries (0..2)
module pipe_stage_reg #(
  parameter int unsigned OP_W        = 14,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned RD_W        = 5,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [DATA_W-1:0] rgS1_data_in,
  input  logic [DATA_W-1:0] rgS2_data_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [RD_W-1:0]   rgD_index_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   opcode_out,
  output logic [DATA_W-1:0] rgS1_data_out,
  output logic [DATA_W-1:0] rgS2_data_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [RD_W-1:0]   rgD_index_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t   state_q;
  state_t   state_d;
  payload_t main_q;
  payload_t skid_q;
  payload_t main_d;
  payload_t in_pl;
  payload_t vis_pl;
  logic     main_we;
  logic     skid_we;
  logic     accept;
  logic     consume;

  // Pack incoming fields into one payload word.
  always_comb begin
    in_pl        = '0;
    in_pl.opcode = opcode_in;
    in_pl.rs1    = rgS1_data_in;
    in_pl.rs2    = rgS2_data_in;
    in_pl.ctrl   = control_in;
    in_pl.rd     = rgD_index_in;
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_we) main_q <= main_d;
      if (skid_we) skid_q <= in_pl;
    end
  end

  // Next state and payload load enables; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_we = 1'b0;
    skid_we = 1'b0;
    main_d  = in_pl;
    accept  = in_valid & in_ready;
    consume = out_valid & out_ready;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_we = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && consume) begin
            main_we = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_we = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid entry moves up to main; in_ready is low so nothing new arrives.
          if (consume) begin
            state_d = ST_BUSY;
            main_we = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs: handshake flags from state only, payload optionally zeroed when idle.
  always_comb begin
    in_ready  = ~reset & (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    case (state_q)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    vis_pl = main_q;
    if (ZERO_BUBBLE && !out_valid) vis_pl = '0;
    opcode_out    = vis_pl.opcode;
    rgS1_data_out = vis_pl.rs1;
    rgS2_data_out = vis_pl.rs2;
    control_out   = vis_pl.ctrl;
    rgD_index_out = vis_pl.rd;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: scoreboard model of the two-entry buffer plus
// a vector table for back-pressure/flush and hand sequences for reset and a
// wide ZERO_BUBBLE=0 instance.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [13:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
  } payload_t;

  typedef struct packed {
    logic [13:0] op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [3:0]  ctrl;
    logic [5:0]  rd;
  } w_payload_t;

  typedef struct {
    logic       flush;
    logic       in_valid;
    int         tag;
    logic       out_ready;
    logic       exp_ir;
    logic       exp_ov;
    logic [1:0] exp_occ;
    int         exp_s2;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  payload_t   in_pl;
  logic       in_ready;
  logic       out_valid;
  logic [13:0] op_o;
  logic [31:0] s1_o;
  logic [31:0] s2_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_o;
  logic [1:0]  occupancy;

  logic        w_reset;
  logic        w_flush;
  logic        w_in_valid;
  logic        w_out_ready;
  w_payload_t  w_in;
  logic        w_in_ready;
  logic        w_out_valid;
  w_payload_t  w_act;
  logic [1:0]  w_occ;

  int checks;
  int failures;
  bit sb_on;
  payload_t sb[$];
  vec_t vecs[13];

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(in_pl.op), .rgS1_data_in(in_pl.s1), .rgS2_data_in(in_pl.s2),
    .control_in(in_pl.ctrl), .rgD_index_in(in_pl.rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(op_o), .rgS1_data_out(s1_o), .rgS2_data_out(s2_o),
    .control_out(ctrl_o), .rgD_index_out(rd_o), .occupancy(occupancy)
  );

  pipe_stage_reg #(.OP_W(14), .DATA_W(64), .CTRL_W(4), .RD_W(6), .ZERO_BUBBLE(1'b0)) dut_w (
    .clk(clk), .reset(w_reset), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode_in(w_in.op), .rgS1_data_in(w_in.s1), .rgS2_data_in(w_in.s2),
    .control_in(w_in.ctrl), .rgD_index_in(w_in.rd),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .opcode_out(w_act.op), .rgS1_data_out(w_act.s1), .rgS2_data_out(w_act.s2),
    .control_out(w_act.ctrl), .rgD_index_out(w_act.rd), .occupancy(w_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic payload_t mk(input int tag);
    payload_t p;
    p.op   = 14'(tag * 7);
    p.s1   = 32'hC0DE_0000 | 32'(tag);
    p.s2   = 32'(tag);
    p.ctrl = 4'(tag);
    p.rd   = 5'(tag);
    return p;
  endfunction

  // Compare DUT against the queue model, then advance the model for this edge.
  task automatic sb_step();
    logic     exp_ir;
    logic     exp_ov;
    payload_t exp_pl;
    payload_t act_pl;
    exp_ir = !reset && (sb.size() < 2);
    exp_ov = (sb.size() != 0);
    exp_pl = exp_ov ? sb[0] : '0;
    act_pl.op = op_o; act_pl.s1 = s1_o; act_pl.s2 = s2_o;
    act_pl.ctrl = ctrl_o; act_pl.rd = rd_o;
    chk("sb_in_ready", 160'(in_ready), 160'(exp_ir));
    chk("sb_out_valid", 160'(out_valid), 160'(exp_ov));
    chk("sb_occupancy", 160'(occupancy), 160'(sb.size()));
    chk("sb_payload", 160'(act_pl), 160'(exp_pl));
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (exp_ov && out_ready) void'(sb.pop_front());
      if (in_valid && exp_ir) sb.push_back(in_pl);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (sb_on) sb_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ov_cnt;
    logic ir_all;
    w_payload_t w_exp;
    checks = 0; failures = 0; sb_on = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pl = '0;
    w_reset = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_in = '0;

    vecs[0]  = '{1'b0, 1'b1, 'h11, 1'b0, 1'b1, 1'b0, 2'd0, 0};
    vecs[1]  = '{1'b0, 1'b1, 'h22, 1'b0, 1'b1, 1'b1, 2'd1, 'h11};
    vecs[2]  = '{1'b0, 1'b1, 'h33, 1'b0, 1'b0, 1'b1, 2'd2, 'h11};
    vecs[3]  = '{1'b0, 1'b1, 'h33, 1'b0, 1'b0, 1'b1, 2'd2, 'h11};
    vecs[4]  = '{1'b0, 1'b1, 'h33, 1'b1, 1'b0, 1'b1, 2'd2, 'h11};
    vecs[5]  = '{1'b0, 1'b1, 'h33, 1'b1, 1'b1, 1'b1, 2'd1, 'h22};
    vecs[6]  = '{1'b0, 1'b0, 0,     1'b1, 1'b1, 1'b1, 2'd1, 'h33};
    vecs[7]  = '{1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0, 2'd0, 0};
    vecs[8]  = '{1'b0, 1'b1, 'h44, 1'b0, 1'b1, 1'b0, 2'd0, 0};
    vecs[9]  = '{1'b0, 1'b1, 'h55, 1'b0, 1'b1, 1'b1, 2'd1, 'h44};
    vecs[10] = '{1'b1, 1'b1, 'h66, 1'b1, 1'b0, 1'b1, 2'd2, 'h44};
    vecs[11] = '{1'b0, 1'b0, 0,     1'b1, 1'b1, 1'b0, 2'd0, 0};
    vecs[12] = '{1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0, 2'd0, 0};

    // Two reset cycles, then check reset state on both instances.
    @(posedge clk); #1;
    sb_on = 1'b1;
    tick();
    reset = 1'b0; w_reset = 1'b0;
    #1;
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_occupancy", 160'(occupancy), 160'(0));
    chk("rst_w_out_valid", 160'(w_out_valid), 160'(0));
    chk("rst_w_payload", 160'(w_act), 160'(0));

    // Single transfer.
    in_pl = '{14'h1A5, 32'hDEADBEEF, 32'h55, 4'h3, 5'h15};
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("single_out_valid", 160'(out_valid), 160'(1));
    chk("single_opcode", 160'(op_o), 160'(14'h1A5));
    chk("single_s1", 160'(s1_o), 160'(32'hDEADBEEF));
    chk("single_occupancy", 160'(occupancy), 160'(1));
    in_valid = 1'b0;
    tick();
    chk("single_idle_valid", 160'(out_valid), 160'(0));
    chk("single_idle_opcode", 160'(op_o), 160'(0));
    chk("single_idle_s1", 160'(s1_o), 160'(0));
    chk("single_idle_rd", 160'(rd_o), 160'(0));

    // Streaming 8 payloads with out_ready held high.
    ov_cnt = 0; ir_all = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_pl = mk(i); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      if (out_valid) ov_cnt++;
      ir_all = ir_all & in_ready;
      chk($sformatf("stream_s2_%0d", i), 160'(s2_o), 160'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_ov_count", 160'(ov_cnt), 160'(8));
    chk("stream_in_ready", 160'(ir_all), 160'(1));
    chk("stream_drained", 160'(out_valid), 160'(0));

    // Back-pressure and flush vectors.
    for (int i = 0; i < 13; i++) begin
      flush = vecs[i].flush; in_valid = vecs[i].in_valid;
      in_pl = mk(vecs[i].tag); out_ready = vecs[i].out_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 160'(in_ready), 160'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 160'(out_valid), 160'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_occupancy", i), 160'(occupancy), 160'(vecs[i].exp_occ));
      chk($sformatf("vec%0d_s2", i), 160'(s2_o), 160'(vecs[i].exp_s2));
      sb_step();
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset while full.
    in_pl = mk('h31); in_valid = 1'b1;
    tick();
    in_pl = mk('h32);
    tick();
    chk("midrst_full", 160'(occupancy), 160'(2));
    in_valid = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_in_ready_low", 160'(in_ready), 160'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 160'(out_valid), 160'(0));
    chk("midrst_occupancy", 160'(occupancy), 160'(0));
    chk("midrst_rd", 160'(rd_o), 160'(0));
    chk("midrst_in_ready_high", 160'(in_ready), 160'(1));
    tick();

    // Wide instance with ZERO_BUBBLE=0: bit-exact transfer and value retention.
    w_exp = '{14'h2AB, 64'hFFFF_0000_1234_5678, 64'h0123_4567_89AB_CDEF, 4'h9, 6'h3F};
    w_in = w_exp; w_in_valid = 1'b1; w_out_ready = 1'b1;
    tick();
    chk("wide_out_valid", 160'(w_out_valid), 160'(1));
    chk("wide_payload", 160'(w_act), 160'(w_exp));
    chk("wide_occupancy", 160'(w_occ), 160'(1));
    w_in_valid = 1'b0; w_in = '0;
    tick();
    chk("wide_idle_valid", 160'(w_out_valid), 160'(0));
    chk("wide_retained", 160'(w_act), 160'(w_exp));
    chk("wide_idle_occupancy", 160'(w_occ), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the ID/EX boundary and any other stage boundary. It generalises the plain write-enabled ID/EX latch: payload field widths are parameters, and it adds valid/ready flow control and a two-entry skid buffer. It also supports flush and bubble insertion. `in_ready` is driven from state only, so back-pressure from the downstream stage never forms a combinational path to the upstream stage.

Parameters:
OP_W, 14, opcode field width
DATA_W, 32, width of each source-operand data field
CTRL_W, 4, control field width
RD_W, 5, destination register index width
ZERO_BUBBLE, 1, 1 = payload outputs forced to 0 while out_valid=0; 0 = payload outputs show main-register contents unconditionally

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (branch/exception kill)
in_valid  in  1  upstream presents a valid payload
in_ready  out  1  stage can accept a payload this cycle
opcode_in  in  OP_W  opcode payload
rgS1_data_in  in  DATA_W  source 1 data payload
rgS2_data_in  in  DATA_W  source 2 data payload
control_in  in  CTRL_W  control payload
rgD_index_in  in  RD_W  destination register index payload
out_valid  out  1  main register holds a valid payload
out_ready  in  1  downstream consumes the payload this cycle
opcode_out  out  OP_W  opcode from main register
rgS1_data_out  out  DATA_W  source 1 data from main register
rgS2_data_out  out  DATA_W  source 2 data from main register
control_out  out  CTRL_W  control from main register
rgD_index_out  out  RD_W  destination index from main register
occupancy  out  2  number of held entries: 0, 1 or 2

Behaviour:
- Storage: a main register (drives the outputs) and a skid register. Each holds the full payload, opcode+2*DATA_W+CTRL_W+RD_W bits; no field is truncated.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- States: EMPTY (occupancy 0), BUSY (main valid, occupancy 1), FULL (main and skid valid, occupancy 2).
- in_ready = !reset & (state != FULL). in_ready is a function of registered state only and never depends on out_ready.
- out_valid = (state != EMPTY).
- EMPTY:
  - accept -> BUSY, main <= in.
- BUSY:
  - accept & consume -> BUSY, main <= in.
  - accept & !consume -> FULL, skid <= in, main holds.
  - !accept & consume -> EMPTY.
  - otherwise hold.
- FULL:
  - consume -> BUSY, main <= skid.
  - otherwise hold. in_ready=0, so no accept is possible.
- Latency: a payload accepted in EMPTY appears on the outputs with out_valid=1 the next cycle. Order is strictly FIFO; no payload is dropped or duplicated.
- Throughput: one payload per cycle when out_ready is held high.
- Flush:
  - Next state is EMPTY. flush has priority over accept and consume in the same cycle; an accept in a flush cycle is discarded.
  - Payload registers are not cleared by flush. With ZERO_BUBBLE=1 the outputs read 0 regardless.
- Reset (synchronous, highest priority):
  - State EMPTY; main and skid payloads cleared to 0; occupancy 0; out_valid 0.
  - in_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
  - Reset mid-transfer discards all held entries.
- Payload outputs when out_valid=0: 0 if ZERO_BUBBLE=1, otherwise the last main-register contents.
- Payload is never sampled when in_valid=0. Skid contents are don't-care while the skid is invalid, but are 0 after reset.
- Upstream contract: once asserted, in_valid and the input payload stay stable until accepted or flushed. Violations are not checked.

Test Plan:
- Reset then single transfer: reset 2 cycles, then in_valid=1, opcode_in=14'h1A5, rgS1=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, opcode_out=14'h1A5, rgS1_data_out=32'hDEADBEEF, occupancy=1; the following cycle (no new input) out_valid=0 and outputs 0.
- Streaming: 8 back-to-back payloads with rgS2 = 1..8 and out_ready=1 -> 8 consecutive out_valid cycles, rgS2_data_out = 1..8 in order, in_ready stays 1 throughout.
- Back-pressure: out_ready=0 while payloads A, B, C are offered -> A and B accepted, occupancy=2, in_ready=0 and C held. Raise out_ready -> outputs A, B, C in order; in_ready returns to 1 the cycle after A is consumed.
- Flush with full buffer: occupancy=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, outputs 0; the payload offered in the flush cycle never appears.
- Reset mid-operation: occupancy=2, assert reset for 1 cycle -> out_valid=0, occupancy=0, rgD_index_out=0; in_ready=0 during reset and 1 the cycle after.
- Widths: ZERO_BUBBLE=0, DATA_W=64, RD_W=6, payload rgS1=64'hFFFF_0000_1234_5678, rgD_index=6'h3F -> output bit-exact, and with out_valid=0 the outputs retain the last value.
